// File: rtl/descriptor_pack_if.sv
// Element-in / descriptor-out bus for descriptor_pack.
// master: the stream source plus the descriptor consumer; slave: the packer.
interface descriptor_pack_if #(
   parameter int Descriptor_bits            = 13,
   parameter int SIFTDescriptor_output_bits = 1664
);
   logic                                  ivalid;
   logic                                  istart;
   logic [Descriptor_bits-1:0]            idata;
   logic                                  iready;
   logic                                  odval;
   logic                                  oready;
   logic [SIFTDescriptor_output_bits-1:0] odata;
   logic                                  oerr;
   logic [15:0]                           ocount;

   modport master (
      output ivalid, istart, idata, oready,
      input  iready, odval, odata, oerr, ocount
   );

   modport slave (
      input  ivalid, istart, idata, oready,
      output iready, odval, odata, oerr, ocount
   );
endinterface

// File: rtl/descriptor_pack.sv
// Packs a stream of descriptor elements into one wide descriptor word.
// Elements land in an assembly buffer; the last element copies the whole
// buffer into the output register in a single edge, so the assembly
// buffer can refill while the previous descriptor waits for the consumer.
module descriptor_pack #(
   parameter int Descriptor_bits            = 13,
   parameter int SIFTDescriptor_output_size = 128,
   parameter int SIFTDescriptor_output_bits = 1664
) (
   input logic               iclk,
   input logic               ireset,
   descriptor_pack_if.slave  bus
);

   localparam int W  = Descriptor_bits;
   localparam int N  = SIFTDescriptor_output_size;
   localparam int B  = SIFTDescriptor_output_bits;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LastIdx = CW'(N - 1);

   logic [CW-1:0] cnt;
   logic [B-1:0]  asm_buf;
   logic [B-1:0]  odata_q;
   logic          odval_q;
   logic          oerr_q;
   logic [15:0]   ocount_q;

   logic          ready;
   logic          accept;
   logic          restart;
   logic          last_elem;
   logic [CW-1:0] slot;

   // Stall only when the last slot is pending and the output is still occupied;
   // built from registers so there is no path from oready/ivalid.
   assign ready     = !((cnt == LastIdx) && odval_q);
   assign accept    = bus.ivalid & ready;
   assign restart   = accept & bus.istart;
   assign last_elem = accept & !bus.istart & (cnt == LastIdx);
   assign slot      = bus.istart ? '0 : cnt;

   assign bus.iready = ready;
   assign bus.odval  = odval_q;
   assign bus.odata  = odata_q;
   assign bus.oerr   = oerr_q;
   assign bus.ocount = ocount_q;

   // Element index: restart jumps to 1, final slot wraps to 0.
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         cnt <= '0;
      end else if (accept) begin
         if (bus.istart) begin
            cnt <= CW'(1);
         end else if (cnt == LastIdx) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Assembly buffer: store each accepted element unmodified in its slot.
   // Stale slots after a restart are simply overwritten later.
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         asm_buf <= '0;
      end else if (accept) begin
         for (int i = 0; i < N; i++) begin
            if (slot == CW'(i)) begin
               asm_buf[i*W +: W] <= bus.idata;
            end
         end
      end
   end

   // Output register: the last element bypasses the buffer so the whole
   // descriptor is visible one cycle after its final accept.
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         odata_q  <= '0;
         odval_q  <= 1'b0;
         ocount_q <= '0;
      end else begin
         if (last_elem) begin
            odata_q  <= {bus.idata, asm_buf[B-W-1:0]};
            odval_q  <= 1'b1;
            ocount_q <= ocount_q + 16'd1;
         end else if (odval_q && bus.oready) begin
            odval_q  <= 1'b0;
         end
      end
   end

   // Restart error: one-cycle pulse when istart interrupts a partial descriptor.
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         oerr_q <= 1'b0;
      end else begin
         oerr_q <= restart && (cnt != '0);
      end
   end

endmodule

// File: tb/tb_descriptor_pack.sv
// Directed bench for descriptor_pack: a table of single-descriptor streams
// plus hand-written sequences for back-pressure, restart, reset and wrap.
module tb_descriptor_pack;

   localparam int W = 13;
   localparam int N = 128;
   localparam int B = 1664;

   logic iclk;
   logic ireset;

   descriptor_pack_if #(.Descriptor_bits(W), .SIFTDescriptor_output_bits(B)) bus ();

   descriptor_pack #(
      .Descriptor_bits(W),
      .SIFTDescriptor_output_size(N),
      .SIFTDescriptor_output_bits(B)
   ) dut (
      .iclk(iclk),
      .ireset(ireset),
      .bus(bus)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   int tests  = 0;
   int failed = 0;

   // monitor: counts on the falling edge, away from the active edge
   int cyc        = 0;
   int oerr_seen  = 0;
   int rise_cnt   = 0;
   int rise_last  = 0;
   int rise_prev  = 0;
   int rdy_low    = 0;
   logic odval_d  = 1'b0;

   always @(negedge iclk) begin
      cyc <= cyc + 1;
      if (bus.oerr) oerr_seen <= oerr_seen + 1;
      if (!bus.iready) rdy_low <= rdy_low + 1;
      if (bus.odval && !odval_d) begin
         rise_cnt  <= rise_cnt + 1;
         rise_prev <= rise_last;
         rise_last <= cyc;
      end
      odval_d <= bus.odval;
   end

   typedef struct {
      int base;
      int step;
      bit use_start;
      bit bubble;
      int exp_count;
   } vec_t;

   vec_t vecs[4];

   logic [15:0] exp_cnt;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // compare every slot against base+step*(first+i), reported as one comparison
   task automatic check_odata(input string name, input int base, input int step, input int first);
      int bad = 0;
      int bad_idx = -1;
      logic [W-1:0] e;
      logic [W-1:0] g;
      logic [W-1:0] bad_got = '0;
      logic [W-1:0] bad_exp = '0;
      for (int i = 0; i < N; i++) begin
         e = W'(base + step * (first + i));
         g = bus.odata[i*W +: W];
         if (g !== e) begin
            if (bad == 0) begin
               bad_idx = i;
               bad_got = g;
               bad_exp = e;
            end
            bad++;
         end
      end
      tests++;
      if (bad != 0) begin
         failed++;
         $display("FAIL %s: %0d bad slots, slot %0d got %0d expected %0d",
                  name, bad, bad_idx, bad_got, bad_exp);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   // present one element and hold it until accepted (bounded wait)
   task automatic send_elem(input logic [W-1:0] d, input logic s);
      int waited = 0;
      bus.ivalid = 1'b1;
      bus.istart = s;
      bus.idata  = d;
      while (!bus.iready && waited < 300) begin
         tick();
         waited++;
      end
      if (!bus.iready) begin
         tests++;
         failed++;
         $display("FAIL send_timeout: iready got 0 expected 1 after %0d cycles", waited);
      end
      tick();
      bus.ivalid = 1'b0;
      bus.istart = 1'b0;
      bus.idata  = '0;
   endtask

   // elements first..last of the stream base+step*i
   task automatic send_range(input int base, input int step, input int first, input int last,
                             input bit start_first, input bit bubble);
      for (int i = first; i <= last; i++) begin
         if (bubble && (i % 3 == 2)) tick();
         send_elem(W'(base + step * i), start_first && (i == first));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time got limit expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int oerr0, rise0, rdy0;

      vecs[0] = '{base: 0,      step: 1,    use_start: 1'b1, bubble: 1'b0, exp_count: 1};
      vecs[1] = '{base: 8191,   step: 8191, use_start: 1'b0, bubble: 1'b0, exp_count: 2};
      vecs[2] = '{base: 100,    step: 37,   use_start: 1'b1, bubble: 1'b1, exp_count: 3};
      vecs[3] = '{base: 'h1555, step: 0,    use_start: 1'b0, bubble: 1'b1, exp_count: 4};

      ireset     = 1'b1;
      bus.ivalid = 1'b0;
      bus.istart = 1'b0;
      bus.idata  = '0;
      bus.oready = 1'b1;
      exp_cnt    = '0;

      #3 ireset = 1'b0;
      #4;
      check("rst_iready", 32'(bus.iready), 1);
      check("rst_odval",  32'(bus.odval), 0);
      check("rst_oerr",   32'(bus.oerr), 0);
      check("rst_ocount", 32'(bus.ocount), 0);
      check("rst_odata",  32'(bus.odata == '0), 1);
      repeat (2) @(posedge iclk);
      @(negedge iclk) ireset = 1'b1;
      tick();

      // single descriptors, oready held high
      for (int v = 0; v < 4; v++) begin
         oerr0 = oerr_seen;
         send_range(vecs[v].base, vecs[v].step, 0, N - 2, vecs[v].use_start, vecs[v].bubble);
         check($sformatf("vec%0d_odval_early", v), 32'(bus.odval), 0);
         send_elem(W'(vecs[v].base + vecs[v].step * (N - 1)), 1'b0);
         check($sformatf("vec%0d_odval", v), 32'(bus.odval), 1);
         check_odata($sformatf("vec%0d_odata", v), vecs[v].base, vecs[v].step, 0);
         check($sformatf("vec%0d_ocount", v), 32'(bus.ocount), 32'(vecs[v].exp_count));
         tick();
         check($sformatf("vec%0d_odval_clear", v), 32'(bus.odval), 0);
         repeat (2) tick();
         check($sformatf("vec%0d_oerr", v), 32'(oerr_seen - oerr0), 0);
      end
      exp_cnt = 16'd4;

      // two descriptors back to back at full rate
      rise0 = rise_cnt;
      rdy0  = rdy_low;
      send_range(1000, 5, 0, 2 * N - 1, 1'b1, 1'b0);
      check_odata("b2b_odata", 1000, 5, N);
      repeat (3) tick();
      exp_cnt = exp_cnt + 16'd2;
      check("b2b_iready_low", 32'(rdy_low - rdy0), 0);
      check("b2b_pulses",     32'(rise_cnt - rise0), 2);
      check("b2b_spacing",    32'(rise_last - rise_prev), 128);
      check("b2b_ocount",     32'(bus.ocount), 32'(exp_cnt));

      // back-pressure: A waits, B fills up to its last slot
      bus.oready = 1'b0;
      send_range(100, 1, 0, N - 1, 1'b1, 1'b0);
      exp_cnt = exp_cnt + 16'd1;
      check("bp_a_odval", 32'(bus.odval), 1);
      check_odata("bp_a_odata", 100, 1, 0);
      send_range(200, 1, 0, N - 2, 1'b1, 1'b0);
      check("bp_iready_low", 32'(bus.iready), 0);
      check_odata("bp_a_held", 100, 1, 0);
      bus.ivalid = 1'b1;
      bus.istart = 1'b0;
      bus.idata  = W'(200 + N - 1);
      repeat (3) tick();
      check("bp_stall_iready", 32'(bus.iready), 0);
      check("bp_stall_ocount", 32'(bus.ocount), 32'(exp_cnt));
      check_odata("bp_stall_odata", 100, 1, 0);
      bus.oready = 1'b1;
      tick();
      check("bp_consume_odval",  32'(bus.odval), 0);
      check("bp_consume_iready", 32'(bus.iready), 1);
      bus.oready = 1'b0;
      tick();
      bus.ivalid = 1'b0;
      bus.idata  = '0;
      exp_cnt = exp_cnt + 16'd1;
      check("bp_b_odval", 32'(bus.odval), 1);
      check_odata("bp_b_odata", 200, 1, 0);
      check("bp_b_ocount", 32'(bus.ocount), 32'(exp_cnt));
      bus.oready = 1'b1;
      tick();
      check("bp_b_consumed", 32'(bus.odval), 0);

      // restart at element 50
      oerr0 = oerr_seen;
      rise0 = rise_cnt;
      send_range(3, 1, 0, 49, 1'b1, 1'b0);
      send_elem(W'(7), 1'b1);
      check("rs_oerr_pulse", 32'(bus.oerr), 1);
      tick();
      check("rs_oerr_drop", 32'(bus.oerr), 0);
      send_range(7, 0, 1, N - 1, 1'b0, 1'b0);
      exp_cnt = exp_cnt + 16'd1;
      check("rs_odval", 32'(bus.odval), 1);
      check_odata("rs_odata", 7, 0, 0);
      check("rs_ocount", 32'(bus.ocount), 32'(exp_cnt));
      repeat (3) tick();
      check("rs_oerr_count", 32'(oerr_seen - oerr0), 1);
      check("rs_pulses",     32'(rise_cnt - rise0), 1);

      // ocount wrap
      force dut.ocount_q = 16'hFFFF;
      tick();
      release dut.ocount_q;
      check("wrap_preload", 32'(bus.ocount), 65535);
      send_range(4000, 1, 0, N - 1, 1'b1, 1'b0);
      check("wrap_ocount", 32'(bus.ocount), 0);
      check_odata("wrap_odata", 4000, 1, 0);
      repeat (2) tick();

      // reset mid-descriptor, with an undelivered descriptor present
      bus.oready = 1'b0;
      send_range(300, 1, 0, N - 1, 1'b1, 1'b0);
      send_range(50, 2, 0, 59, 1'b1, 1'b0);
      #2 ireset = 1'b0;
      #1;
      check("mrst_odval",  32'(bus.odval), 0);
      check("mrst_ocount", 32'(bus.ocount), 0);
      check("mrst_odata",  32'(bus.odata == '0), 1);
      check("mrst_iready", 32'(bus.iready), 1);
      @(negedge iclk) ireset = 1'b1;
      tick();
      bus.oready = 1'b1;
      send_range(500, 3, 0, N - 1, 1'b0, 1'b0);
      check("mrst_new_odval", 32'(bus.odval), 1);
      check_odata("mrst_new_odata", 500, 3, 0);
      check("mrst_new_ocount", 32'(bus.ocount), 1);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/descriptor_pack.md
DESCRIPTOR_PACK -- requirements
Module: descriptor_pack

Interface
REQ-001 Parameter Descriptor_bits, 13, width of one descriptor element (from SIFT_Parameter.v).
REQ-002 Parameter SIFTDescriptor_output_size, 128, elements per descriptor (from SIFT_Parameter.v).
REQ-003 Parameter SIFTDescriptor_output_bits, 1664, packed descriptor width = Descriptor_bits * SIFTDescriptor_output_size (from SIFT_Parameter.v).
REQ-004 iclk  input  1  single clock; all state updates on its rising edge.
REQ-005 ireset  input  1  reset, asynchronous, active-low.
REQ-006 ivalid  input  1  element valid.
REQ-007 istart  input  1  marks first element of a descriptor; qualified by accept.
REQ-008 idata  input  Descriptor_bits  one unsigned descriptor element.
REQ-009 iready  output  1  block can accept an element this cycle.
REQ-010 odval  output  1  packed descriptor valid; held until consumed.
REQ-011 oready  input  1  downstream consumes odata when high with odval.
REQ-012 odata  output  SIFTDescriptor_output_bits  packed descriptor, element i at bits [Descriptor_bits*(i+1)-1 : Descriptor_bits*i].
REQ-013 oerr  output  1  one-cycle pulse: descriptor restarted before completion.
REQ-014 ocount  output  16  count of descriptors delivered to odata, wraps 65535->0.

Function
REQ-015 Accept SHALL be ivalid & iready; idata/istart SHALL be ignored when accept is low.
REQ-016 An element index counter cnt (0..SIFTDescriptor_output_size-1) SHALL select the assembly slot; each accept writes idata to slot cnt (or slot 0 per REQ-017) and advances cnt.
REQ-017 Accept with istart=1 SHALL write slot 0 and set cnt=1; if cnt!=0 at that cycle, oerr SHALL pulse high the next cycle and the partial descriptor SHALL be discarded (slots beyond 0 not cleared, overwritten later).
REQ-018 Accept with istart=0 at cnt=0 SHALL be taken as element 0 (istart optional for aligned streams).
REQ-019 Accept at cnt=SIFTDescriptor_output_size-1 with istart=0 SHALL copy the assembly buffer, including this element, to odata, set odval=1, set cnt=0, increment ocount, all visible the cycle after the accept (latency 1).
REQ-020 iready SHALL be low exactly when cnt=SIFTDescriptor_output_size-1 and odval=1; iready SHALL be derived from registers only (no combinational path from oready or ivalid).
REQ-021 Consequently a load to odata SHALL never coincide with odval=1 and an undelivered descriptor SHALL never be overwritten.
REQ-022 odval & oready SHALL clear odval the next cycle; odata SHALL remain stable while odval=1 and hold its last value after.
REQ-023 Elements 0..SIFTDescriptor_output_size-2 SHALL be accepted while odval=1 (double buffering); back-to-back descriptors at one element per cycle SHALL sustain full rate when oready is held high.
REQ-024 Elements SHALL be stored unmodified; no arithmetic on data.

Reset
REQ-025 On ireset low, asynchronously: cnt=0, odval=0, oerr=0, ocount=0, odata=0, assembly buffer=0; iready SHALL read 1 during and after reset.
REQ-026 Reset mid-descriptor SHALL discard the partial descriptor and any undelivered odata; first accept after release is element 0.

Verification
REQ-027 Stream 128 accepts, istart on first, idata=i, oready=1 -> odval high one cycle after 128th accept, odata slot i = i, ocount=1, oerr never high.
REQ-028 Two descriptors back-to-back (256 consecutive accepts), oready=1 -> iready never low, two odval pulses 128 cycles apart, ocount=2.
REQ-029 oready=0, send descriptor A (values 100+i) then 127 elements of B -> iready low at cnt=127, odata stays A; raise oready one cycle -> odval drops, iready rises, B's final element loads, odata = B.
REQ-030 istart at accepted element 50, then 128 elements of new descriptor (values 7) -> oerr one pulse one cycle after restart, single odval, all slots = 7, ocount=1.
REQ-031 Assert ireset after 60 elements -> outputs zero asynchronously; 128 fresh elements after release -> one correct descriptor, ocount=1.
REQ-032 Preload ocount to 65535 via 65535 descriptors (or force in sim), deliver one more -> ocount=0; ivalid high with iready low -> element not consumed, stream unchanged.
